// File: rtl/encode_raw_jtag_uart_reply.sv
// Host-bound JTAG-UART encoder: queues reply bytes and ACK/ERROR events, applies 0xFE escaping,
// and writes the stream into the JTAG-UART Avalon slave without exceeding the polled WSPACE.
module encode_raw_jtag_uart_reply #(
    parameter int          FIFO_AW  = 4,
    parameter logic [7:0]  ESC_BYTE = 8'hFE,
    parameter logic [7:0]  ESC_CHAR = 8'h00,
    parameter logic [7:0]  ESC_ACK  = 8'h01,
    parameter logic [7:0]  ESC_ERR  = 8'h02,
    parameter logic [7:0]  POLL_GAP = 8'd64
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    input  logic [7:0]  iDATA,
    input  logic        iDATA_VALID,
    output logic        oDATA_READY,
    input  logic        iSEND_ACK,
    input  logic        iSEND_ERROR,
    output logic        oBUSY,
    output logic [1:0]  oDBG_STATE,
    output logic [15:0] oDBG_CREDIT
);
    // Handshakes: input bytes move when iDATA_VALID & oDATA_READY at a clock edge; an Avalon
    // request (RDREQ or WRREQ) with its ADDR/WRDATA stays stable until the edge where WAIT=0.
    typedef enum logic [1:0] {IDLE = 2'd0, POLL = 2'd1, GAP = 2'd2, WRITE = 2'd3} state_t;

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
    logic             ready_q, ready_d;
    logic             pend_ack_q, pend_ack_d, pend_err_q, pend_err_d;
    logic             push, pop, fifo_nempty, load, load_ack, load_err;
    logic [7:0]       head, tok_b0, tok_b1, cur_byte;
    logic             tok_two;

    state_t      state_q;
    logic [7:0]  b0_q, b1_q, wrdata_q, gap_q;
    logic        two_q, half_q, rdreq_q, wrreq_q, addr_q;
    logic [15:0] credit_q;
    logic        unused_rddata;

    assign unused_rddata = ^iJTAG_SLAVE_RDDATA[15:0];

    // Token selection at a token boundary: error, then ack, then FIFO data.
    always_comb begin
        fifo_nempty = (wr_ptr_q != rd_ptr_q);
        head        = mem_q[rd_ptr_q[FIFO_AW-1:0]];
        load        = (state_q == IDLE) && (pend_err_q || pend_ack_q || fifo_nempty);
        load_err    = load && pend_err_q;
        load_ack    = load && !pend_err_q && pend_ack_q;
        pop         = load && !pend_err_q && !pend_ack_q;
        push        = iDATA_VALID && ready_q;
        tok_b0      = ESC_BYTE;
        tok_b1      = ESC_CHAR;
        tok_two     = 1'b1;
        if (pend_err_q) begin
            tok_b1 = ESC_ERR;
        end else if (pend_ack_q) begin
            tok_b1 = ESC_ACK;
        end else if (head != ESC_BYTE) begin
            tok_b0  = head;
            tok_two = 1'b0;
        end
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = wr_ptr_d - rd_ptr_d;
        ready_d    = (count_d != FULL_CNT);
        pend_ack_d = (pend_ack_q && !load_ack) || iSEND_ACK;
        pend_err_d = (pend_err_q && !load_err) || iSEND_ERROR;
        cur_byte   = half_q ? b1_q : b0_q;
    end

    always_ff @(posedge iCLK) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= iDATA;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            pend_ack_q <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            pend_ack_q <= pend_ack_d;
            pend_err_q <= pend_err_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            b0_q     <= '0;
            b1_q     <= '0;
            two_q    <= 1'b0;
            half_q   <= 1'b0;
            credit_q <= '0;
            gap_q    <= '0;
            rdreq_q  <= 1'b0;
            wrreq_q  <= 1'b0;
            addr_q   <= 1'b0;
            wrdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    b0_q   <= tok_b0;
                    b1_q   <= tok_b1;
                    two_q  <= tok_two;
                    half_q <= 1'b0;
                    if (credit_q == 16'd0) begin
                        state_q <= POLL;
                        rdreq_q <= 1'b1;
                        addr_q  <= 1'b1;
                    end else begin
                        state_q  <= WRITE;
                        wrreq_q  <= 1'b1;
                        addr_q   <= 1'b0;
                        wrdata_q <= tok_b0;
                    end
                end
                POLL: if (!iJTAG_SLAVE_WAIT) begin
                    rdreq_q  <= 1'b0;
                    addr_q   <= 1'b0;
                    credit_q <= iJTAG_SLAVE_RDDATA[31:16];
                    if (iJTAG_SLAVE_RDDATA[31:16] == 16'd0) begin
                        state_q <= GAP;
                        gap_q   <= '0;
                    end else begin
                        state_q  <= WRITE;
                        wrreq_q  <= 1'b1;
                        wrdata_q <= cur_byte;
                    end
                end
                GAP: begin
                    if (gap_q == POLL_GAP - 8'd1) begin
                        state_q <= POLL;
                        rdreq_q <= 1'b1;
                        addr_q  <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                WRITE: if (!iJTAG_SLAVE_WAIT) begin
                    credit_q <= credit_q - 16'd1;
                    // Second half of an escape pair never yields to a new token.
                    if (two_q && !half_q) begin
                        half_q <= 1'b1;
                        if (credit_q == 16'd1) begin
                            state_q <= POLL;
                            wrreq_q <= 1'b0;
                            rdreq_q <= 1'b1;
                            addr_q  <= 1'b1;
                        end else begin
                            wrdata_q <= b1_q;
                        end
                    end else begin
                        state_q <= IDLE;
                        wrreq_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oJTAG_SLAVE_ADDR   = addr_q;
    assign oJTAG_SLAVE_RDREQ  = rdreq_q;
    assign oJTAG_SLAVE_WRREQ  = wrreq_q;
    assign oJTAG_SLAVE_WRDATA = {24'd0, wrdata_q};
    assign oDATA_READY        = ready_q;
    assign oBUSY              = fifo_nempty || pend_ack_q || pend_err_q || (state_q != IDLE);
    assign oDBG_STATE         = state_q;
    assign oDBG_CREDIT        = credit_q;
endmodule

// File: tb/tb_encode_raw_jtag_uart_reply.sv
// Directed bench for encode_raw_jtag_uart_reply: Avalon slave model, expected-byte queue and
// a negedge monitor that checks every accepted write and poll.
module tb_encode_raw_jtag_uart_reply;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        addr, rdreq, wrreq, wait_r, valid, ready, send_ack, send_err, busy;
    logic [31:0] rddata, wrdata;
    logic [7:0]  data;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_credit, wspace_val, bcredit;
    logic [7:0]  exp_q[$];
    int          total = 0, bad = 0, poll_cnt = 0, wr_cnt = 0, gap_cycles = 0;

    always #5 clk = ~clk;
    assign rddata = {wspace_val, 16'h00A5};

    encode_raw_jtag_uart_reply dut (
        .iCLK(clk), .iRST_N(rst_n),
        .oJTAG_SLAVE_ADDR(addr), .oJTAG_SLAVE_RDREQ(rdreq), .iJTAG_SLAVE_RDDATA(rddata),
        .oJTAG_SLAVE_WRREQ(wrreq), .oJTAG_SLAVE_WRDATA(wrdata), .iJTAG_SLAVE_WAIT(wait_r),
        .iDATA(data), .iDATA_VALID(valid), .oDATA_READY(ready),
        .iSEND_ACK(send_ack), .iSEND_ERROR(send_err), .oBUSY(busy),
        .oDBG_STATE(dbg_state), .oDBG_CREDIT(dbg_credit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on each accepted write; also models the host-side credit.
    initial begin
        bcredit = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcredit = '0;
            end else begin
                if (dbg_state == 2'd2) gap_cycles++;
                if (rdreq && !wait_r) begin
                    poll_cnt++;
                    check("poll_addr", {31'd0, addr}, 32'd1);
                    bcredit = rddata[31:16];
                end
                if (wrreq) begin
                    if (exp_q.size() == 0) begin
                        if (!wait_r) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_write actual=%0h required=none", wrdata);
                        end
                    end else if (wait_r) begin
                        check("hold_data", wrdata, {24'd0, exp_q[0]});
                    end else begin
                        check("wr_data", wrdata, {24'd0, exp_q.pop_front()});
                        check("wr_addr", {31'd0, addr}, 32'd0);
                        check("no_overrun", {31'd0, bcredit != 16'd0}, 32'd1);
                        wr_cnt++;
                        if (bcredit != 16'd0) bcredit = bcredit - 16'd1;
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] b);
        if (b == 8'hFE) begin
            exp_q.push_back(8'hFE);
            exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic acc;
        data  = b;
        valid = 1'b1;
        do begin
            acc = ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=ready_low required=accept");
        end else begin
            push_exp(b);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    // what: 0 = second half (0x00) on the bus, 1 = GAP state, 2 = any write request.
    task automatic wait_until(input int what);
        int n = 0;
        logic hit;
        do begin
            case (what)
                0:       hit = wrreq && (wrdata[7:0] == 8'h00);
                1:       hit = (dbg_state == 2'd2);
                default: hit = wrreq;
            endcase
            if (!hit) begin
                @(posedge clk); #1;
                n++;
            end
        end while (!hit && n < 500);
        check("wait_event", {31'd0, hit}, 32'd1);
    endtask

    task automatic clear_counts();
        poll_cnt   = 0;
        wr_cnt     = 0;
        gap_cycles = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        clear_counts();
        @(posedge clk); #1;
    endtask

    initial begin
        int accepted;
        valid = 1'b0; data = '0; send_ack = 1'b0; send_err = 1'b0;
        wait_r = 1'b0; wspace_val = 16'd64;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdreq",  {31'd0, rdreq}, 32'd0);
        check("rst_wrreq",  {31'd0, wrreq}, 32'd0);
        check("rst_addr",   {31'd0, addr},  32'd0);
        check("rst_wrdata", wrdata,         32'd0);
        check("rst_ready",  {31'd0, ready}, 32'd0);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_credit", {16'd0, dbg_credit}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, ready}, 32'd1);

        // Two plain bytes, one poll of WSPACE=64.
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle();
        check("t1_polls",  poll_cnt, 32'd1);
        check("t1_writes", wr_cnt,   32'd2);
        check("t1_credit", {16'd0, dbg_credit}, 32'd62);

        // Escaped byte; ACK raised while the pair is in flight follows the pair.
        send_byte(8'hFE);
        wait_until(0);
        send_ack = 1'b1;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h01);
        @(posedge clk); #1;
        send_ack = 1'b0;
        wait_idle();
        check("t2_credit", {16'd0, dbg_credit}, 32'd58);

        // Simultaneous events: error pair first.
        send_err = 1'b1;
        send_ack = 1'b1;
        exp_q.push_back(8'hFE); exp_q.push_back(8'h02);
        exp_q.push_back(8'hFE); exp_q.push_back(8'h01);
        @(posedge clk); #1;
        send_err = 1'b0;
        send_ack = 1'b0;
        wait_idle();
        check("t3_credit", {16'd0, dbg_credit}, 32'd54);

        // WSPACE=0 then 1: one 64-cycle gap, repoll between halves of a pair.
        pulse_reset();
        wspace_val = 16'd0;
        send_byte(8'h55);
        wait_until(1);
        wspace_val = 16'd1;
        wait_idle();
        check("t4_gap_cycles", gap_cycles, 32'd64);
        check("t4_polls_a",    poll_cnt,   32'd2);
        check("t4_writes_a",   wr_cnt,     32'd1);
        send_byte(8'hFE);
        wait_idle();
        check("t4_polls_b",  poll_cnt, 32'd4);
        check("t4_writes_b", wr_cnt,   32'd3);
        check("t4_credit",   {16'd0, dbg_credit}, 32'd0);

        // Waitrequest held for five cycles on a write.
        wspace_val = 16'd64;
        clear_counts();
        send_byte(8'h33);
        wait_until(2);
        wait_r = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("t5_wrreq_held", {31'd0, wrreq}, 32'd1);
        end
        wait_r = 1'b0;
        wait_idle();
        check("t5_writes", wr_cnt, 32'd1);
        check("t5_credit", {16'd0, dbg_credit}, 32'd63);

        // Fill the FIFO with no space, then reset in the middle of a write.
        pulse_reset();
        wspace_val = 16'd0;
        accepted = 0;
        valid = 1'b1;
        for (int i = 0; i < 40 && ready; i++) begin
            data = 8'h10 + 8'(i);
            @(posedge clk); #1;
            accepted++;
        end
        valid = 1'b0;
        check("t6_accepted", accepted, 32'd17);
        check("t6_ready_full", {31'd0, ready}, 32'd0);
        wspace_val = 16'd64;
        wait_until(2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wrreq", {31'd0, wrreq}, 32'd0);
        check("t6_rst_rdreq", {31'd0, rdreq}, 32'd0);
        check("t6_rst_busy",  {31'd0, busy},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        clear_counts();
        @(posedge clk); #1;
        check("t6_ready_empty", {31'd0, ready}, 32'd1);
        check("t6_busy_empty",  {31'd0, busy},  32'd0);
        send_byte(8'h77);
        wait_idle();
        check("t6_writes", wr_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
